ringbuffer_readout: RTL and testbench

Trigger-driven reader for the ADC sample ring buffer. The ADC side writes continuously. On a trigger, this block captures a window of PRE pre-trigger and POST post-trigger samples. It waits until all post-trigger samples have been written, then drives the ring buffer's read port (rd_en/ain, 1-cycle read latency). The samples are delivered in order on a valid/ready stream toward the event builder.

---
 rtl/ringbuffer_pkg.sv | 23 ++
 rtl/readout_skid2.sv | 71 +++++++
 rtl/ringbuffer_readout.sv | 186 ++++++++++++++++++
 tb/tb_ringbuffer_readout.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ringbuffer_pkg.sv
// +--------------------------------------------------------------------------+
// | ringbuffer_pkg                                                           |
// | Types and shared defaults for the ADC sample ring buffer and its reader. |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

package ringbuffer_pkg;

   // Defaults shared with the ring buffer writer
   localparam int c_rb_size  = 12;
   localparam int c_rb_width = 14;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_POST = 2'd1,
      ST_READ      = 2'd2,
      ST_DRAIN     = 2'd3
   } rb_state_t;

endpackage

`default_nettype wire

// File: rtl/readout_skid2.sv
// +--------------------------------------------------------------------------+
// | readout_skid2                                                            |
// | Two-entry output buffer with empty-bypass; reports occupancy for credit. |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module readout_skid2 #(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_valid,
   input  logic [DW-1:0] i_data,
   output logic          o_valid,
   output logic [DW-1:0] o_data,
   input  logic          i_ready,
   output logic [1:0]    o_count
);

   logic [DW-1:0] r_mem [2];
   logic          r_rd_ptr;
   logic          r_wr_ptr;
   logic [1:0]    r_count;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;

   // An incoming word goes straight out when nothing is queued ahead of it;
   // it is only stored when it cannot leave in the cycle it arrives.
   always_comb begin
      w_empty = (r_count == 2'd0);
      w_pop   = !w_empty && i_ready;
      w_push  = i_valid && !(w_empty && i_ready);
      o_valid = !w_empty || i_valid;
      o_data  = '0;
      if (!w_empty) begin
         o_data = r_mem[r_rd_ptr];
      end else if (i_valid) begin
         o_data = i_data;
      end
   end

   assign o_count = r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/ringbuffer_readout.sv
// +--------------------------------------------------------------------------+
// | ringbuffer_readout                                                       |
// | Trigger-driven window reader: waits for post-trigger samples, then       |
// | streams PRE+POST samples from the ring buffer in order.                  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module ringbuffer_readout
   import ringbuffer_pkg::*;
#(
   parameter int SIZE  = c_rb_size,
   parameter int WIDTH = c_rb_width,
   parameter int PRE   = 32,
   parameter int POST  = 96
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_trigger,
   input  logic             i_rb_wr_en,
   input  logic [SIZE-1:0]  i_rb_aout,
   input  logic [WIDTH-1:0] i_rb_dout,
   output logic             o_rb_rd_en,
   output logic [SIZE-1:0]  o_rb_ain,
   output logic [WIDTH-1:0] o_m_data,
   output logic             o_m_valid,
   input  logic             i_m_ready,
   output logic             o_m_first,
   output logic             o_m_last,
   output logic             o_busy,
   output logic             o_overrun
);

   localparam int c_cw = SIZE + 1;
   localparam int c_ww = SIZE + 2;
   localparam int c_dw = WIDTH + 2;

   localparam logic [c_cw-1:0] c_total = c_cw'(PRE + POST);
   localparam logic [c_cw-1:0] c_post  = c_cw'(POST);
   localparam logic [SIZE-1:0] c_pre   = SIZE'(PRE);
   localparam logic [c_ww-1:0] c_room  = c_ww'((2 ** SIZE) - PRE);
   localparam logic [c_ww-1:0] c_wmax  = {c_ww{1'b1}};

   rb_state_t       r_state;
   rb_state_t       w_state_nxt;
   logic [SIZE-1:0] r_start;
   logic [c_cw-1:0] r_post_cnt;
   logic [c_ww-1:0] r_wr_cnt;
   logic [c_ww-1:0] w_wr_cnt_inc;
   logic [c_cw-1:0] r_rd_idx;
   logic            r_inflight;
   logic            r_if_first;
   logic            r_if_last;
   logic            r_overrun;
   logic [1:0]      w_count;
   logic            w_credit_ok;
   logic            w_rd_issue;
   logic            w_last_issue;
   logic [c_dw-1:0] w_skid_in;
   logic [c_dw-1:0] w_skid_out;

   // Credit: buffered words plus the one read in flight must stay below two
   always_comb begin
      w_credit_ok  = (w_count == 2'd0) || ((w_count == 2'd1) && !r_inflight);
      w_rd_issue   = (r_state == ST_READ) && (r_rd_idx < c_total) && w_credit_ok;
      w_last_issue = w_rd_issue && (r_rd_idx == c_total - c_cw'(1));
      w_wr_cnt_inc = r_wr_cnt;
      if (i_rb_wr_en && (r_wr_cnt != c_wmax)) begin
         w_wr_cnt_inc = r_wr_cnt + c_ww'(1);
      end
   end

   assign o_rb_rd_en = w_rd_issue;
   assign o_rb_ain   = w_rd_issue ? (r_start + r_rd_idx[SIZE-1:0]) : '0;
   assign o_busy     = (r_state != ST_IDLE);
   assign o_overrun  = r_overrun;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (i_trigger) begin
               w_state_nxt = (i_rb_wr_en && (POST == 1)) ? ST_READ : ST_WAIT_POST;
            end
         end
         ST_WAIT_POST: begin
            if (i_rb_wr_en && ((r_post_cnt + c_cw'(1)) == c_post)) begin
               w_state_nxt = ST_READ;
            end
         end
         ST_READ: begin
            if (w_last_issue) begin
               w_state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (o_m_valid && i_m_ready && o_m_last) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // The trigger cycle's own write is the first post-trigger sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_start    <= '0;
         r_post_cnt <= '0;
         r_wr_cnt   <= '0;
         r_rd_idx   <= '0;
         r_overrun  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_trigger) begin
                  r_start    <= i_rb_aout - c_pre;
                  r_post_cnt <= i_rb_wr_en ? c_cw'(1) : '0;
                  r_wr_cnt   <= i_rb_wr_en ? c_ww'(1) : '0;
                  r_rd_idx   <= '0;
                  r_overrun  <= 1'b0;
               end
            end
            ST_WAIT_POST: begin
               if (i_rb_wr_en) begin
                  r_post_cnt <= r_post_cnt + c_cw'(1);
               end
               r_wr_cnt <= w_wr_cnt_inc;
            end
            ST_READ: begin
               r_wr_cnt <= w_wr_cnt_inc;
               if (w_rd_issue) begin
                  r_rd_idx <= r_rd_idx + c_cw'(1);
                  if (r_wr_cnt > c_room) begin
                     r_overrun <= 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_inflight <= 1'b0;
         r_if_first <= 1'b0;
         r_if_last  <= 1'b0;
      end else begin
         r_inflight <= w_rd_issue;
         r_if_first <= w_rd_issue && (r_rd_idx == '0);
         r_if_last  <= w_last_issue;
      end
   end

   assign w_skid_in = {r_if_first, r_if_last, i_rb_dout};

   readout_skid2 #(
      .DW (c_dw)
   ) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (r_inflight),
      .i_data  (w_skid_in),
      .o_valid (o_m_valid),
      .o_data  (w_skid_out),
      .i_ready (i_m_ready),
      .o_count (w_count)
   );

   assign o_m_first = w_skid_out[c_dw-1];
   assign o_m_last  = w_skid_out[c_dw-2];
   assign o_m_data  = w_skid_out[WIDTH-1:0];

endmodule

`default_nettype wire

// File: tb/tb_ringbuffer_readout.sv
// +--------------------------------------------------------------------------+
// | tb_ringbuffer_readout                                                    |
// | Scoreboard bench: two readers (SIZE=6 and SIZE=4) on modelled buffers.   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_ringbuffer_readout;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Instance A: SIZE=6, PRE=4, POST=8
   logic        a_trig = 1'b0;
   logic        a_wr_en = 1'b1;
   logic [5:0]  a_aout = '0;
   logic [13:0] a_seq = '0;
   logic [13:0] a_dout = '0;
   logic [13:0] a_mem [64];
   logic        a_rd_en;
   logic [5:0]  a_ain;
   logic [13:0] a_data;
   logic        a_valid;
   logic        a_ready = 1'b0;
   logic        a_first;
   logic        a_last;
   logic        a_busy;
   logic        a_ovr;
   int          a_rmode = 0;
   logic [15:0] a_q [$];

   // Instance B: SIZE=4, PRE=4, POST=8
   logic        b_trig = 1'b0;
   logic        b_wr_en = 1'b1;
   logic [3:0]  b_aout = '0;
   logic [13:0] b_seq = '0;
   logic [13:0] b_dout = '0;
   logic [13:0] b_mem [16];
   logic        b_rd_en;
   logic [3:0]  b_ain;
   logic [13:0] b_data;
   logic        b_valid;
   logic        b_ready = 1'b0;
   logic        b_first;
   logic        b_last;
   logic        b_busy;
   logic        b_ovr;
   logic [1:0]  b_q [$];

   ringbuffer_readout #(.SIZE(6), .WIDTH(14), .PRE(4), .POST(8)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .i_trigger(a_trig), .i_rb_wr_en(a_wr_en),
      .i_rb_aout(a_aout), .i_rb_dout(a_dout), .o_rb_rd_en(a_rd_en), .o_rb_ain(a_ain),
      .o_m_data(a_data), .o_m_valid(a_valid), .i_m_ready(a_ready), .o_m_first(a_first),
      .o_m_last(a_last), .o_busy(a_busy), .o_overrun(a_ovr)
   );

   ringbuffer_readout #(.SIZE(4), .WIDTH(14), .PRE(4), .POST(8)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .i_trigger(b_trig), .i_rb_wr_en(b_wr_en),
      .i_rb_aout(b_aout), .i_rb_dout(b_dout), .o_rb_rd_en(b_rd_en), .o_rb_ain(b_ain),
      .o_m_data(b_data), .o_m_valid(b_valid), .i_m_ready(b_ready), .o_m_first(b_first),
      .o_m_last(b_last), .o_busy(b_busy), .o_overrun(b_ovr)
   );

   // Ring buffer models: each slot holds the global write sequence number
   initial begin
      for (int i = 0; i < 64; i++) a_mem[i] = '0;
      for (int i = 0; i < 16; i++) b_mem[i] = '0;
   end

   always @(posedge clk) begin
      if (a_wr_en) begin
         a_mem[a_aout] <= a_seq;
         a_aout        <= a_aout + 6'd1;
         a_seq         <= a_seq + 14'd1;
      end
      if (a_rd_en) a_dout <= a_mem[a_ain];
      if (b_wr_en) begin
         b_mem[b_aout] <= b_seq;
         b_aout        <= b_aout + 4'd1;
         b_seq         <= b_seq + 14'd1;
      end
      if (b_rd_en) b_dout <= b_mem[b_ain];
   end

   task automatic fail(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      if (act !== req) begin
         fail(nm, act, req);
      end else begin
         checks++;
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Window of sequence numbers trig-4 .. trig+7 with markers on the ends
   task automatic push_a(input logic [13:0] trig_seq);
      for (int i = 0; i < 12; i++) begin
         a_q.push_back({(i == 0), (i == 11), 14'(trig_seq - 14'd4 + 14'(i))});
      end
   endtask

   task automatic push_b();
      for (int i = 0; i < 12; i++) b_q.push_back({(i == 0), (i == 11)});
   endtask

   task automatic wait_seq_a(input int target);
      for (int k = 0; k < 400 && a_seq != 14'(target); k++) cyc(1);
      chk("a_reach_seq", 32'(a_seq), 32'(target));
   endtask

   task automatic wait_idle_a(input int budget);
      for (int k = 0; k < budget && (a_busy || a_q.size() != 0); k++) cyc(1);
      chk("a_window_done", 32'(a_busy || a_q.size() != 0), 32'd0);
   endtask

   task automatic wait_idle_b(input int budget);
      for (int k = 0; k < budget && (b_busy || b_q.size() != 0); k++) cyc(1);
      chk("b_window_done", 32'(b_busy || b_q.size() != 0), 32'd0);
   endtask

   // Ready driver for A: 0 = always ready, 1 = ~30% ready, else stalled
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (a_rmode == 0)      a_ready = 1'b1;
         else if (a_rmode == 1) a_ready = ($urandom_range(0, 99) < 30);
         else                   a_ready = 1'b0;
      end
   end

   // Monitor A: scoreboard pop on acceptance, hold check on stalls
   logic        a_pv = 1'b0;
   logic        a_pr = 1'b0;
   logic [15:0] a_pw = '0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (a_pv && !a_pr) begin
            chk("a_hold_valid", 32'(a_valid), 32'd1);
            chk("a_hold_word", 32'({a_first, a_last, a_data}), 32'(a_pw));
         end
         if (a_valid && a_ready) begin
            if (a_q.size() == 0) fail("a_unexpected_sample", 32'(a_data), 32'hffffffff);
            else chk("a_sample", 32'({a_first, a_last, a_data}), 32'(a_q.pop_front()));
         end
      end
      a_pv <= rst_n && a_valid;
      a_pr <= a_ready;
      a_pw <= {a_first, a_last, a_data};
   end

   always @(negedge clk) begin
      if (rst_n && b_valid && b_ready) begin
         if (b_q.size() == 0) fail("b_unexpected_sample", 32'(b_data), 32'hffffffff);
         else chk("b_markers", 32'({b_first, b_last}), 32'(b_q.pop_front()));
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      cyc(3);
      chk("a_reset_outputs", 32'({a_rd_en, a_ain, a_valid, a_data, a_first, a_last, a_busy, a_ovr}), 32'd0);
      chk("b_reset_outputs", 32'({b_rd_en, b_ain, b_valid, b_data, b_first, b_last, b_busy, b_ovr}), 32'd0);
      rst_n = 1'b1;
      cyc(2);

      // Basic window: trigger at address 20 -> addresses 16..27
      wait_seq_a(20);
      a_trig = 1'b1;
      push_a(a_seq);
      cyc(1);
      a_trig = 1'b0;
      chk("a_busy_after_trigger", 32'(a_busy), 32'd1);
      cyc(6);
      chk("a_no_read_before_post", 32'(a_rd_en), 32'd0);
      cyc(1);
      chk("a_first_rd_en", 32'(a_rd_en), 32'd1);
      chk("a_first_rd_addr", 32'(a_ain), 32'd16);
      cyc(1);
      chk("a_first_valid", 32'({a_valid, a_first}), 32'd3);
      cyc(11);
      chk("a_last_timing", 32'({a_valid, a_last}), 32'd3);
      chk("a_busy_at_last", 32'(a_busy), 32'd1);
      a_trig = 1'b1;
      cyc(1);
      chk("a_busy_fell", 32'(a_busy), 32'd0);
      push_a(a_seq);
      cyc(1);
      a_trig = 1'b0;
      chk("a_retrigger_busy", 32'(a_busy), 32'd1);
      wait_idle_a(200);
      chk("a_no_overrun", 32'(a_ovr), 32'd0);

      // Wrap at address 2 (62,63,0..9) under backpressure, stray triggers ignored
      a_rmode = 1;
      wait_seq_a(130);
      a_trig = 1'b1;
      push_a(a_seq);
      cyc(1);
      a_trig = 1'b0;
      cyc(2);
      a_trig = 1'b1;
      cyc(1);
      a_trig = 1'b0;
      cyc(6);
      a_trig = 1'b1;
      cyc(1);
      a_trig = 1'b0;
      wait_idle_a(600);
      a_rmode = 0;
      cyc(5);
      chk("a_stray_trigger_idle", 32'({a_busy, a_valid}), 32'd0);

      // Asynchronous reset in the middle of READ
      a_trig = 1'b1;
      push_a(a_seq);
      cyc(1);
      a_trig = 1'b0;
      cyc(10);
      #2;
      rst_n = 1'b0;
      #1;
      chk("a_async_reset_outputs", 32'({a_rd_en, a_ain, a_valid, a_data, a_first, a_last, a_busy, a_ovr}), 32'd0);
      a_q.delete();
      cyc(1);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("a_idle_after_reset", 32'({a_busy, a_valid, a_rd_en}), 32'd0);
         cyc(1);
      end
      a_trig = 1'b1;
      push_a(a_seq);
      cyc(1);
      a_trig = 1'b0;
      wait_idle_a(200);

      // Overrun on the small buffer: stall 20 cycles past the first read
      b_ready = 1'b0;
      b_trig  = 1'b1;
      push_b();
      cyc(1);
      b_trig = 1'b0;
      cyc(27);
      chk("b_stalled_no_overrun_yet", 32'(b_ovr), 32'd0);
      b_ready = 1'b1;
      wait_idle_b(200);
      chk("b_overrun_set", 32'(b_ovr), 32'd1);
      b_trig = 1'b1;
      push_b();
      cyc(1);
      b_trig = 1'b0;
      chk("b_overrun_cleared", 32'(b_ovr), 32'd0);
      wait_idle_b(200);

      chk("a_queue_empty", 32'(a_q.size()), 32'd0);
      chk("b_queue_empty", 32'(b_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
